// File: rtl/alu_nibble_serial_if.sv
// Handshake and operand/result bundle for alu_nibble_serial.
// master drives the request, slave is the ALU.
interface alu_nibble_serial_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       s;
   logic             m;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] f;
   logic             cout;
   logic             zero;
   logic             aeqb;

   modport master (
      output start, a, b, s, m, cin,
      input  busy, done, f, cout, zero, aeqb
   );

   modport slave (
      input  start, a, b, s, m, cin,
      output busy, done, f, cout, zero, aeqb
   );
endinterface

// File: rtl/alu_nibble_serial.sv
// Multi-cycle 74181-function ALU: SLICES nibbles per clock, LSB group first,
// with the carry held in a register between groups.
module alu_nibble_serial #(
   parameter int WIDTH  = 16,
   parameter int SLICES = 1
) (
   input logic               clk,
   input logic               reset,
   alu_nibble_serial_if.slave bus
);

   localparam int GS = 4 * SLICES;
   localparam int N  = WIDTH / GS;
   localparam int GW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_r, b_r, part;
   logic [3:0]       s_r;
   logic             m_r;
   logic             carry;
   logic [GW-1:0]    grp;
   logic             busy_r, done_r, cout_r, zero_r, aeqb_r;
   logic [WIDTH-1:0] f_r;

   logic [GS-1:0]    a_g, b_g, grp_f;
   logic [WIDTH-1:0] part_next;
   logic             c_top;

   // One 74181 nibble: returns {carry_out, f[3:0]}. Logic mode never carries.
   function automatic logic [4:0] nib_eval(input logic [3:0] x4, input logic [3:0] y4,
                                           input logic [3:0] sel, input logic mode,
                                           input logic c);
      logic [3:0] x, y, l;
      logic [4:0] sum;
      x = '0;
      y = '0;
      l = '0;
      case (sel)
         4'd0:    begin x = x4;        y = 4'h0;     l = ~x4;        end
         4'd1:    begin x = x4 | y4;   y = 4'h0;     l = ~(x4 | y4); end
         4'd2:    begin x = x4 | ~y4;  y = 4'h0;     l = ~x4 & y4;   end
         4'd3:    begin x = 4'h0;      y = 4'hF;     l = 4'h0;       end
         4'd4:    begin x = x4;        y = x4 & ~y4; l = ~(x4 & y4); end
         4'd5:    begin x = x4 | y4;   y = x4 & ~y4; l = ~y4;        end
         4'd6:    begin x = x4;        y = ~y4;      l = x4 ^ y4;    end
         4'd7:    begin x = x4 & ~y4;  y = 4'hF;     l = x4 & ~y4;   end
         4'd8:    begin x = x4;        y = x4 & y4;  l = ~x4 | y4;   end
         4'd9:    begin x = x4;        y = y4;       l = ~(x4 ^ y4); end
         4'd10:   begin x = x4 | ~y4;  y = x4 & y4;  l = y4;         end
         4'd11:   begin x = x4 & y4;   y = 4'hF;     l = x4 & y4;    end
         4'd12:   begin x = x4;        y = x4;       l = 4'hF;       end
         4'd13:   begin x = x4 | y4;   y = x4;       l = x4 | ~y4;   end
         4'd14:   begin x = x4 | ~y4;  y = x4;       l = x4 | y4;    end
         default: begin x = x4;        y = 4'hF;     l = x4;         end
      endcase
      sum = {1'b0, x} + {1'b0, y} + {4'b0, c};
      return mode ? {1'b0, l} : sum;
   endfunction

   // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
   always_comb begin
      logic       c;
      logic [4:0] r;
      c         = carry;
      r         = '0;
      grp_f     = '0;
      a_g       = a_r[int'(grp) * GS +: GS];
      b_g       = b_r[int'(grp) * GS +: GS];
      for (int i = 0; i < SLICES; i++) begin
         r              = nib_eval(a_g[4*i +: 4], b_g[4*i +: 4], s_r, m_r, c);
         grp_f[4*i +: 4] = r[3:0];
         c              = r[4];
      end
      c_top     = c;
      part_next = part;
      part_next[int'(grp) * GS +: GS] = grp_f;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         a_r    <= '0;
         b_r    <= '0;
         s_r    <= '0;
         m_r    <= 1'b0;
         carry  <= 1'b0;
         grp    <= '0;
         part   <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         f_r    <= '0;
         cout_r <= 1'b0;
         zero_r <= 1'b0;
         aeqb_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_r    <= bus.a;
                  b_r    <= bus.b;
                  s_r    <= bus.s;
                  m_r    <= bus.m;
                  carry  <= bus.cin;
                  grp    <= '0;
                  part   <= '0;
                  busy_r <= 1'b1;
                  state  <= RUN;
               end
            end
            default: begin
               part  <= part_next;
               carry <= c_top;
               if (grp == GW'(N - 1)) begin
                  // Flags come from part_next so they register alongside f, not derived from f_r.
                  f_r    <= part_next;
                  cout_r <= m_r ? 1'b0 : c_top;
                  zero_r <= (part_next == '0);
                  aeqb_r <= &part_next;
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
                  grp    <= '0;
                  state  <= IDLE;
               end else begin
                  grp <= grp + 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.f    = f_r;
   assign bus.cout = cout_r;
   assign bus.zero = zero_r;
   assign bus.aeqb = aeqb_r;

endmodule

// File: tb/tb_alu_nibble_serial.sv
// Scoreboard bench for alu_nibble_serial: directed 16-bit vectors plus a
// function sweep over several WIDTH/SLICES configurations.
module tb_alu_nibble_serial;

   typedef struct packed {
      logic [63:0] f;
      logic        cout;
      logic        zero;
      logic        aeqb;
      logic [63:0] cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] cyc = '0;
   int          tests = 0;
   int          fails = 0;

   exp_t q16[$];
   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];
   exp_t qd[$];

   alu_nibble_serial_if #(.WIDTH(16)) if16 ();
   alu_nibble_serial_if #(.WIDTH(32)) ifa ();
   alu_nibble_serial_if #(.WIDTH(32)) ifb ();
   alu_nibble_serial_if #(.WIDTH(32)) ifc ();
   alu_nibble_serial_if #(.WIDTH(4))  ifd ();

   alu_nibble_serial #(.WIDTH(16), .SLICES(1)) dut16 (.clk(clk), .reset(reset), .bus(if16));
   alu_nibble_serial #(.WIDTH(32), .SLICES(8)) duta  (.clk(clk), .reset(reset), .bus(ifa));
   alu_nibble_serial #(.WIDTH(32), .SLICES(2)) dutb  (.clk(clk), .reset(reset), .bus(ifb));
   alu_nibble_serial #(.WIDTH(32), .SLICES(1)) dutc  (.clk(clk), .reset(reset), .bus(ifc));
   alu_nibble_serial #(.WIDTH(4),  .SLICES(1)) dutd  (.clk(clk), .reset(reset), .bus(ifd));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cmp(input string tag, input exp_t e, input logic [63:0] f,
                      input logic cout, input logic zero, input logic aeqb);
      check({tag, "_f"},    f,             e.f);
      check({tag, "_cout"}, {63'b0, cout}, {63'b0, e.cout});
      check({tag, "_zero"}, {63'b0, zero}, {63'b0, e.zero});
      check({tag, "_aeqb"}, {63'b0, aeqb}, {63'b0, e.aeqb});
      check({tag, "_lat"},  cyc,           e.cyc);
   endtask

   task automatic unexpected(input string tag);
      tests++;
      fails++;
      $display("FAIL %s_done: got unexpected done expected none", tag);
   endtask

   // Whole-word reference: direct addend sum at full width, no nibble slicing.
   function automatic exp_t model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                  input logic [3:0] s, input logic m, input logic cin,
                                  input logic [63:0] when);
      logic [63:0] mask, a, b, nb, x, y, res;
      logic [64:0] sum;
      exp_t e;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      a = a_in & mask;
      b = b_in & mask;
      nb = ~b & mask;
      x = '0;
      y = '0;
      res = '0;
      e = '0;
      if (m) begin
         case (s)
            4'd0: res = ~a;       4'd1: res = ~(a | b);  4'd2: res = ~a & b;   4'd3: res = '0;
            4'd4: res = ~(a & b); 4'd5: res = nb;        4'd6: res = a ^ b;    4'd7: res = a & nb;
            4'd8: res = ~a | b;   4'd9: res = ~(a ^ b);  4'd10: res = b;       4'd11: res = a & b;
            4'd12: res = mask;    4'd13: res = a | nb;   4'd14: res = a | b;   default: res = a;
         endcase
         e.cout = 1'b0;
      end else begin
         case (s)
            4'd0: x = a;            4'd1: x = a | b;
            4'd2: x = a | nb;       4'd3: y = mask;
            4'd4: begin x = a; y = a & nb; end
            4'd5: begin x = a | b; y = a & nb; end
            4'd6: begin x = a; y = nb; end
            4'd7: begin x = a & nb; y = mask; end
            4'd8: begin x = a; y = a & b; end
            4'd9: begin x = a; y = b; end
            4'd10: begin x = a | nb; y = a & b; end
            4'd11: begin x = a & b; y = mask; end
            4'd12: begin x = a; y = a; end
            4'd13: begin x = a | b; y = a; end
            4'd14: begin x = a | nb; y = a; end
            default: begin x = a; y = mask; end
         endcase
         sum = {1'b0, x} + {1'b0, y} + {64'b0, cin};
         res = sum[63:0];
         e.cout = sum[w];
      end
      res &= mask;
      e.f = res;
      e.zero = (res == '0);
      e.aeqb = (res == mask);
      e.cyc = when;
      return e;
   endfunction

   always @(negedge clk) if (if16.done) begin
      if (q16.size() == 0) unexpected("w16");
      else cmp("w16", q16.pop_front(), {48'b0, if16.f}, if16.cout, if16.zero, if16.aeqb);
   end
   always @(negedge clk) if (ifa.done) begin
      if (qa.size() == 0) unexpected("w32s8");
      else cmp("w32s8", qa.pop_front(), {32'b0, ifa.f}, ifa.cout, ifa.zero, ifa.aeqb);
   end
   always @(negedge clk) if (ifb.done) begin
      if (qb.size() == 0) unexpected("w32s2");
      else cmp("w32s2", qb.pop_front(), {32'b0, ifb.f}, ifb.cout, ifb.zero, ifb.aeqb);
   end
   always @(negedge clk) if (ifc.done) begin
      if (qc.size() == 0) unexpected("w32s1");
      else cmp("w32s1", qc.pop_front(), {32'b0, ifc.f}, ifc.cout, ifc.zero, ifc.aeqb);
   end
   always @(negedge clk) if (ifd.done) begin
      if (qd.size() == 0) unexpected("w4s1");
      else cmp("w4s1", qd.pop_front(), {60'b0, ifd.f}, ifd.cout, ifd.zero, ifd.aeqb);
   end

   // Called at a negedge; start is seen by the next posedge, done expected 1+4 cycles on.
   task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                          input logic m, input logic cin, input logic [15:0] ef,
                          input logic ec, input logic ez, input logic ee, input bit expect_it);
      if16.a = a;
      if16.b = b;
      if16.s = s;
      if16.m = m;
      if16.cin = cin;
      if16.start = 1'b1;
      if (expect_it) q16.push_back(exp_t'{f: {48'b0, ef}, cout: ec, zero: ez, aeqb: ee, cyc: cyc + 5});
      @(negedge clk);
      if16.start = 1'b0;
      if16.a = 16'hDEAD;
      if16.b = 16'hBEEF;
      if16.s = ~s;
      if16.m = ~m;
      if16.cin = ~cin;
   endtask

   task automatic wait_done16();
      bit got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (if16.done) begin
            got = 1'b1;
            break;
         end
      end
      check("done_seen", {63'b0, got}, 64'd1);
   endtask

   task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                        input logic m, input logic cin, input logic [15:0] ef,
                        input logic ec, input logic ez, input logic ee);
      issue16(a, b, s, m, cin, ef, ec, ez, ee, 1'b1);
      wait_done16();
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] ra, rb;
      {if16.start, ifa.start, ifb.start, ifc.start, ifd.start} = '0;
      {if16.a, if16.b, if16.s, if16.m, if16.cin} = '0;
      {ifa.a, ifa.b, ifa.s, ifa.m, ifa.cin} = '0;
      {ifb.a, ifb.b, ifb.s, ifb.m, ifb.cin} = '0;
      {ifc.a, ifc.b, ifc.s, ifc.m, ifc.cin} = '0;
      {ifd.a, ifd.b, ifd.s, ifd.m, ifd.cin} = '0;

      repeat (3) @(negedge clk);
      check("rst_busy", {63'b0, if16.busy}, 64'd0);
      check("rst_done", {63'b0, if16.done}, 64'd0);
      check("rst_f",    {48'b0, if16.f},    64'd0);
      check("rst_flags", {61'b0, if16.cout, if16.zero, if16.aeqb}, 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // a, b, s, m, cin -> f, cout, zero, aeqb
      run16(16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
      run16(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      run16(16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
      run16(16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
      run16(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 16'h0FF0, 1'b0, 1'b0, 1'b0);
      run16(16'h0000, 16'h1357, 4'b1111, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
      run16(16'h1111, 16'h2222, 4'b1100, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
      run16(16'h8421, 16'h0000, 4'b1100, 1'b0, 1'b1, 16'h0843, 1'b1, 1'b0, 1'b0);

      // Start re-pulsed while busy: must be dropped, one done only.
      issue16(16'h0001, 16'h0002, 4'b1001, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1);
      check("busy_run", {63'b0, if16.busy}, 64'd1);
      if16.a = 16'h7777;
      if16.s = 4'b1100;
      if16.m = 1'b1;
      if16.start = 1'b1;
      @(negedge clk);
      if16.start = 1'b0;
      wait_done16();
      repeat (8) @(negedge clk);

      // Reset two cycles into RUN aborts with no done.
      issue16(16'h4321, 16'h1111, 4'b1001, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_busy", {63'b0, if16.busy}, 64'd0);
      check("abort_done", {63'b0, if16.done}, 64'd0);
      check("abort_f",    {48'b0, if16.f},    64'd0);
      check("abort_flags", {61'b0, if16.cout, if16.zero, if16.aeqb}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run16(16'h00F0, 16'h0F10, 4'b1001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

      // Back-to-back: second start lands in the done cycle.
      issue16(16'h8000, 16'h8000, 4'b1001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
      wait_done16();
      issue16(16'h00FF, 16'h0F0F, 4'b1011, 1'b1, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_done16();
      repeat (6) @(negedge clk);

      // Function sweep across configurations, all four DUTs started together.
      for (int k = 0; k < 64; k++) begin
         logic [3:0] s;
         logic       m, cin;
         s   = 4'(k >> 2);
         m   = k[1];
         cin = k[0];
         ra  = {$urandom, $urandom};
         rb  = {$urandom, $urandom};
         ifa.a = ra[31:0]; ifa.b = rb[31:0]; ifa.s = s; ifa.m = m; ifa.cin = cin;
         ifb.a = ra[31:0]; ifb.b = rb[31:0]; ifb.s = s; ifb.m = m; ifb.cin = cin;
         ifc.a = ra[31:0]; ifc.b = rb[31:0]; ifc.s = s; ifc.m = m; ifc.cin = cin;
         ifd.a = ra[3:0];  ifd.b = rb[3:0];  ifd.s = s; ifd.m = m; ifd.cin = cin;
         {ifa.start, ifb.start, ifc.start, ifd.start} = 4'hF;
         qa.push_back(model(32, ra, rb, s, m, cin, cyc + 2));
         qb.push_back(model(32, ra, rb, s, m, cin, cyc + 5));
         qc.push_back(model(32, ra, rb, s, m, cin, cyc + 9));
         qd.push_back(model(4,  ra, rb, s, m, cin, cyc + 2));
         @(negedge clk);
         {ifa.start, ifb.start, ifc.start, ifd.start} = 4'h0;
         repeat (8) @(negedge clk);
      end
      repeat (12) @(negedge clk);

      check("q16_left", 64'(q16.size()), 64'd0);
      check("qa_left",  64'(qa.size()),  64'd0);
      check("qb_left",  64'(qb.size()),  64'd0);
      check("qc_left",  64'(qc.size()),  64'd0);
      check("qd_left",  64'(qd.size()),  64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
